// File: rtl/spi_slave_responder.sv
// SPI mode-0 (CPOL=0, CPHA=0) MSB-first peripheral responder. SCLK/SS/MOSI are oversampled on clk;
// TX words come in through a single-entry hold register and RX words leave through a ready/valid port.
module spi_slave_responder #(
    parameter int unsigned       DATA_W    = 8,
    parameter logic [DATA_W-1:0] IDLE_FILL = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              ss,
    input  logic              mosi,
    output logic              miso,
    output logic              miso_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              busy,
    output logic              tx_underrun,
    output logic              rx_overrun
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } state_t;

    state_t            state_r;
    logic              sclk_q1_r, sclk_q2_r, sclk_hist_r;
    logic              ss_q1_r, ss_q2_r, ss_hist_r;
    logic              mosi_q1_r, mosi_q2_r;
    logic [DATA_W-1:0] hold_r;
    logic [DATA_W-1:0] tx_shift_r;
    logic [DATA_W-1:0] rx_shift_r;
    logic [CNT_W-1:0]  bit_cnt_r;
    logic              word_done_r;

    logic              sclk_rise_s, sclk_fall_s, ss_rise_s, ss_fall_s;
    logic              tx_write_s, rx_accept_s, do_load_s;
    logic [DATA_W-1:0] load_word_s;

    assign sclk_rise_s = sclk_q2_r & ~sclk_hist_r;
    assign sclk_fall_s = ~sclk_q2_r & sclk_hist_r;
    assign ss_rise_s   = ss_q2_r & ~ss_hist_r;
    assign ss_fall_s   = ~ss_q2_r & ss_hist_r;
    assign tx_write_s  = tx_valid & tx_ready;
    assign rx_accept_s = rx_valid & rx_ready;
    // An empty hold (tx_ready high) supplies the fill word; a same-cycle write lands in hold instead.
    assign load_word_s = tx_ready ? IDLE_FILL : hold_r;
    assign do_load_s   = ~ss_rise_s & ((state_r == ST_LOAD) |
                         ((state_r == ST_SHIFT) & sclk_fall_s & (bit_cnt_r == CNT_FULL)));

    // Two-stage synchronisers plus a history stage; clearing ss low keeps a reset from faking a select edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q1_r   <= 1'b0;
            sclk_q2_r   <= 1'b0;
            sclk_hist_r <= 1'b0;
            ss_q1_r     <= 1'b0;
            ss_q2_r     <= 1'b0;
            ss_hist_r   <= 1'b0;
            mosi_q1_r   <= 1'b0;
            mosi_q2_r   <= 1'b0;
        end else begin
            sclk_q1_r   <= sclk;
            sclk_q2_r   <= sclk_q1_r;
            sclk_hist_r <= sclk_q2_r;
            ss_q1_r     <= ss;
            ss_q2_r     <= ss_q1_r;
            ss_hist_r   <= ss_q2_r;
            mosi_q1_r   <= mosi;
            mosi_q2_r   <= mosi_q1_r;
        end
    end

    // Frame FSM, TX hold, shift registers and the RX word port
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            busy        <= 1'b0;
            tx_ready    <= 1'b1;
            hold_r      <= {DATA_W{1'b0}};
            tx_shift_r  <= {DATA_W{1'b0}};
            rx_shift_r  <= {DATA_W{1'b0}};
            bit_cnt_r   <= CNT_ZERO;
            word_done_r <= 1'b0;
            rx_data     <= {DATA_W{1'b0}};
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            rx_overrun  <= 1'b0;
        end else begin
            tx_underrun <= 1'b0;
            rx_overrun  <= 1'b0;
            word_done_r <= 1'b0;

            if (tx_write_s) begin
                hold_r   <= tx_data;
                tx_ready <= 1'b0;
            end

            if (rx_accept_s) begin
                rx_valid <= 1'b0;
            end

            if (word_done_r) begin
                rx_data  <= rx_shift_r;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_ready) begin
                    rx_overrun <= 1'b1;
                end
            end

            if (ss_rise_s) begin
                state_r   <= ST_IDLE;
                miso      <= 1'b0;
                miso_oe   <= 1'b0;
                busy      <= 1'b0;
                bit_cnt_r <= CNT_ZERO;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        miso_oe <= 1'b0;
                        busy    <= 1'b0;
                        if (ss_fall_s) begin
                            state_r <= ST_LOAD;
                        end
                    end
                    ST_LOAD: begin
                        bit_cnt_r <= CNT_ZERO;
                        state_r   <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        if (sclk_rise_s) begin
                            rx_shift_r <= {rx_shift_r[DATA_W-2:0], mosi_q2_r};
                            bit_cnt_r  <= bit_cnt_r + CNT_ONE;
                            if (bit_cnt_r == CNT_LAST) begin
                                word_done_r <= 1'b1;
                            end
                        end else if (sclk_fall_s) begin
                            if (bit_cnt_r == CNT_FULL) begin
                                bit_cnt_r <= CNT_ZERO;
                            end else if (bit_cnt_r != CNT_ZERO) begin
                                miso       <= tx_shift_r[DATA_W-2];
                                tx_shift_r <= {tx_shift_r[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase

                if (do_load_s) begin
                    tx_shift_r <= load_word_s;
                    miso       <= load_word_s[DATA_W-1];
                    miso_oe    <= 1'b1;
                    busy       <= 1'b1;
                    if (tx_ready) begin
                        tx_underrun <= 1'b1;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_responder.sv
// Bench for spi_slave_responder: an SPI master model driving skewed sclk = clk/4, a queue-based
// reference of the TX hold / RX stream, and a monitor that scores every word the DUT hands over.
module tb_spi_slave_responder;

    localparam int CLK_P = 10;
    localparam int HP    = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0, ss = 1'b1, mosi = 1'b0;
    logic       miso, miso_oe, tx_ready, rx_valid, busy, tx_underrun, rx_overrun;
    logic [7:0] tx_data = 8'h00, rx_data;
    logic       tx_valid = 1'b0, rx_ready = 1'b1;

    int n_checks = 0, n_errors = 0;
    int under_cnt = 0, over_cnt = 0, exp_under = 0, exp_over = 0;
    logic [7:0] rx_exp_q[$];
    logic [7:0] miso_exp_q[$];
    logic [7:0] tx_model_q[$];
    logic [7:0] mosi_words[4];

    always #(CLK_P/2) clk = ~clk;

    spi_slave_responder #(.DATA_W(8), .IDLE_FILL(8'hFF)) dut (
        .clk(clk), .rst(rst), .sclk(sclk), .ss(ss), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .tx_underrun(tx_underrun), .rx_overrun(rx_overrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: counts status pulses and scores every RX word the consumer accepts
    always @(negedge clk) begin
        if (!rst) begin
            if (tx_underrun) under_cnt++;
            if (rx_overrun) over_cnt++;
            if (rx_valid && rx_ready) begin
                if (rx_exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL rx_unexpected: got %0h expected no word", rx_data);
                end else begin
                    check("rx_data", rx_data, rx_exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tx_push(input logic [7:0] d);
        bit done = 1'b0;
        @(posedge clk); #1;
        tx_data  = d;
        tx_valid = 1'b1;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge clk);
            if (tx_ready) begin
                @(posedge clk); #1;
                tx_valid = 1'b0;
                done = 1'b1;
            end
        end
        if (!done) begin
            tx_valid = 1'b0;
            n_checks++;
            n_errors++;
            $display("FAIL tx_handshake: got tx_ready=0 for 50 cycles expected 1");
        end else begin
            tx_model_q.push_back(d);
            @(negedge clk);
            check("tx_ready_after_push", tx_ready, 1'b0);
        end
    endtask

    // One master bit: mosi changes with the falling edge, miso is sampled late in the high phase
    task automatic shift_bit(input logic b, input bit first, output logic m);
        if (!first) sclk = 1'b0;
        mosi = b;
        #HP sclk = 1'b1;
        #(HP-1) m = miso;
        #1;
    endtask

    // Start a frame at a random phase offset to clk (never on a rising clk edge)
    task automatic frame_start();
        int skew;
        skew = $urandom_range(1, 8);
        if (skew >= 5) skew++;
        #(skew);
        ss = 1'b0;
        #(8*CLK_P);
    endtask

    // Frame of nbits; sclk falls together with ss rising so no extra word is started at the end
    task automatic run_frame(input int nbits, input bit rx_scored);
        logic [7:0] rd;
        logic m;
        int loads, full;
        full  = nbits / 8;
        loads = (nbits + 7) / 8;
        if (loads == 0) loads = 1;
        for (int w = 0; w < loads; w++) begin
            logic [7:0] word;
            if (tx_model_q.size() > 0) begin
                word = tx_model_q.pop_front();
            end else begin
                word = 8'hFF;
                exp_under++;
            end
            if (w < full) begin
                miso_exp_q.push_back(word);
                if (rx_scored) rx_exp_q.push_back(mosi_words[w]);
            end
        end
        frame_start();
        check("busy_in_frame", busy, 1'b1);
        check("miso_oe_in_frame", miso_oe, 1'b1);
        rd = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            shift_bit(mosi_words[i/8][7-(i%8)], i == 0, m);
            rd = {rd[6:0], m};
            if (i % 8 == 7) check("miso_word", rd, miso_exp_q.pop_front());
        end
        sclk = 1'b0;
        ss   = 1'b1;
        mosi = 1'b0;
        repeat (4) @(negedge clk);
        check("miso_oe_after_ss", miso_oe, 1'b0);
        check("busy_after_ss", busy, 1'b0);
        repeat (3) @(negedge clk);
        check("underrun_count", under_cnt, exp_under);
        check("overrun_count", over_cnt, exp_over);
    endtask

    initial begin
        logic m;
        int total;

        // Power-on reset
        repeat (3) @(negedge clk);
        check("rst_miso", miso, 1'b0);
        check("rst_miso_oe", miso_oe, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Reset in the middle of a frame: outputs return to reset values, the rest of the frame is ignored
        tx_push(8'h77);
        frame_start();
        for (int i = 0; i < 3; i++) shift_bit(1'b1, i == 0, m);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_miso", miso, 1'b0);
        check("midrst_miso_oe", miso_oe, 1'b0);
        check("midrst_tx_ready", tx_ready, 1'b1);
        check("midrst_rx_valid", rx_valid, 1'b0);
        check("midrst_rx_data", rx_data, 8'h00);
        check("midrst_busy", busy, 1'b0);
        rst = 1'b0;
        tx_model_q.delete();
        for (int i = 0; i < 5; i++) shift_bit(1'b0, 1'b0, m);
        @(negedge clk);
        check("ignored_miso_oe", miso_oe, 1'b0);
        check("ignored_busy", busy, 1'b0);
        check("ignored_rx_valid", rx_valid, 1'b0);
        sclk = 1'b0;
        ss   = 1'b1;
        repeat (8) @(negedge clk);

        // Single word with a queued TX word
        tx_push(8'hA5);
        mosi_words[0] = 8'h3C;
        run_frame(8, 1'b1);

        // Two-word frame with nothing queued
        mosi_words[0] = 8'h01;
        mosi_words[1] = 8'h80;
        run_frame(16, 1'b1);

        // Overrun: consumer stalls across two words
        @(posedge clk); #1 rx_ready = 1'b0;
        mosi_words[0] = 8'h11;
        mosi_words[1] = 8'h22;
        exp_over++;
        run_frame(16, 1'b0);
        check("overrun_rx_valid", rx_valid, 1'b1);
        check("overrun_rx_data", rx_data, 8'h22);
        rx_exp_q.push_back(8'h22);
        @(posedge clk); #1 rx_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("overrun_drained", rx_valid, 1'b0);

        // Abort after 5 bits of 8'hF0, then a full frame
        mosi_words[0] = 8'hF0;
        run_frame(5, 1'b1);
        check("abort_rx_valid", rx_valid, 1'b0);
        tx_push(8'h5A);
        mosi_words[0] = 8'hC3;
        run_frame(8, 1'b1);

        // Randomised frames of 1..3 words at random phase
        total = 0;
        while (total < 32) begin
            int nw;
            nw = $urandom_range(1, 3);
            if (nw > 32 - total) nw = 32 - total;
            for (int w = 0; w < nw; w++) mosi_words[w] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) tx_push(8'($urandom));
            run_frame(nw * 8, 1'b1);
            total += nw;
        end

        repeat (4) @(negedge clk);
        check("rx_queue_empty", rx_exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
